param_array_pq: RTL and testbench
=================================

PARAM_ARRAY_PQ -- requirements
Module: param_array_pq

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, number of queue cells (>=2).
REQ-002 SHALL provide parameter DATA_WIDTH, default 16, priority key width.
REQ-003 SHALL provide parameter ID_WIDTH, default $clog2(DEPTH)+1, tag width carried with each key.
REQ-004 SHALL provide parameter MAX_FIRST, default 0, ordering mode: 0 = smallest key at head, 1 = largest key at head.
REQ-005 SHALL have clk_i  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have rst_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have push_i  input  1  insert request.
REQ-008 SHALL have push_data_i  input  DATA_WIDTH  key to insert.
REQ-009 SHALL have push_id_i  input  ID_WIDTH  tag to insert.
REQ-010 SHALL have pop_i  input  1  remove-head request.
REQ-011 SHALL have head_valid_o  output  1  head cell holds an entry.
REQ-012 SHALL have head_data_o  output  DATA_WIDTH  head key.
REQ-013 SHALL have head_id_o  output  ID_WIDTH  head tag.
REQ-014 SHALL have count_o  output  $clog2(DEPTH+1)  number of stored entries.
REQ-015 SHALL have full_o / empty_o  output  1 each  count_o==DEPTH / count_o==0.
REQ-016 SHALL have overflow_o / underflow_o  output  1 each  one-cycle error pulses.

Function
REQ-017 SHALL store entries in a register array cell[0..DEPTH-1] of {valid, data, id}, kept sorted with highest priority in cell[0] and valid cells contiguous from 0.
REQ-018 SHALL drive head_*_o, count_o, full_o, empty_o directly from registers; an operation sampled at edge N is visible after edge N (one-cycle latency, one operation per cycle, no stalls).
REQ-019 Priority: MAX_FIRST=0 -> unsigned smaller key wins; MAX_FIRST=1 -> unsigned larger key wins; equal keys SHALL keep insertion order (FIFO among ties).
REQ-020 Push only (not full): new entry SHALL be placed at first index whose cell is invalid or strictly lower priority; cells from that index SHALL shift one toward DEPTH-1; count +1.
REQ-021 Pop only (not empty): all cells SHALL shift one toward 0, cell[DEPTH-1] becomes invalid; count -1.
REQ-022 Push+pop (not empty): head SHALL be removed and new entry inserted in the same cycle with correct ordering; count unchanged; no overflow even when full.
REQ-023 Pop when empty (with or without push): pop SHALL be ignored, underflow_o SHALL pulse one cycle; a simultaneous push SHALL still be performed.
REQ-024 Push only when full: behaviour per REQ-029/REQ-030; overflow_o SHALL pulse one cycle.
REQ-025 Empty head: head_data_o and head_id_o SHALL read 0 when head_valid_o=0.
REQ-026 Key comparisons SHALL use exactly DATA_WIDTH bits, no sign extension; count_o SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-027 With rst_i=1 at an edge, all cells SHALL be invalid and zeroed: head_valid_o=0, head_data_o=0, head_id_o=0, count_o=0, full_o=0, empty_o=1, overflow_o=0, underflow_o=0.
REQ-028 rst_i SHALL take precedence over push_i/pop_i in the same cycle; queue contents SHALL be discarded mid-operation.

Configuration
REQ-029 With macro PQ_EVICT_EN defined: push when full SHALL insert the new entry if strictly higher priority than cell[DEPTH-1], discarding cell[DEPTH-1]; otherwise the new entry is dropped; count stays DEPTH.
REQ-030 Without PQ_EVICT_EN: push when full SHALL be dropped and the array left unchanged.

Verification
REQ-031 DEPTH=4, MAX_FIRST=0: push keys 30,10,20 on consecutive cycles -> after third edge head_data_o=10, count_o=3; pops return 10,20,30 then empty_o=1.
REQ-032 Tie order: push (5,id1),(5,id2),(3,id3) -> pops yield id3,id1,id2.
REQ-033 Full, no macro: fill DEPTH=4 with 1,2,3,4, push 0 -> overflow_o=1 one cycle, head_data_o=1, count_o=4; with PQ_EVICT_EN -> head_data_o=0, key 4 gone.
REQ-034 Push+pop on full queue {1,2,3,4} with key 2 -> head_data_o=2, count_o=4, overflow_o=0; pops yield 2,2,3,4.
REQ-035 Pop on empty with push key 7 -> underflow_o=1, head_data_o=7, count_o=1; MAX_FIRST=1 push 3,9,5 -> head_data_o=9.
REQ-036 Assert rst_i with count_o=3 while push_i=1 -> next cycle empty_o=1, count_o=0, head_valid_o=0.

Source files
------------

// File: rtl/param_array_pq.sv
// Sorted register-array priority queue: head in cell[0], FIFO order among equal keys.
// Optional macro PQ_EVICT_EN: a push into a full queue evicts the lowest-priority cell.
module param_array_pq #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(DEPTH) + 1,
  parameter int MAX_FIRST  = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  input  logic [ID_WIDTH-1:0]        push_id_i,
  input  logic                       pop_i,
  output logic                       head_valid_o,
  output logic [DATA_WIDTH-1:0]      head_data_o,
  output logic [ID_WIDTH-1:0]        head_id_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  valid_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [ID_WIDTH-1:0]   id_q    [DEPTH];
  logic                  valid_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [DEPTH];
  logic [ID_WIDTH-1:0]   id_d    [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Base array after an optional pop, before the insertion is applied.
  logic                  b_valid [DEPTH];
  logic [DATA_WIDTH-1:0] b_data  [DEPTH];
  logic [ID_WIDTH-1:0]   b_id    [DEPTH];
  logic [DEPTH-1:0]      ge;
  logic                  do_pop, ins_en, evict_ok, prev_ge;
  logic                  c_valid;
  logic [DATA_WIDTH-1:0] c_data;
  logic [ID_WIDTH-1:0]   c_id;
  logic [CW-1:0]         base_count;

  // Strictly-higher priority test; ties lose so equal keys stay in arrival order.
  function automatic logic wins(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (MAX_FIRST != 0) begin
      return a > b;
    end else begin
      return a < b;
    end
  endfunction

  // Next-state computation: pop shift, insertion point search, shift-insert, status.
  always_comb begin
    do_pop = pop_i && !empty_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      b_valid[i] = do_pop ? valid_q[i+1] : valid_q[i];
      b_data[i]  = do_pop ? data_q[i+1]  : data_q[i];
      b_id[i]    = do_pop ? id_q[i+1]    : id_q[i];
    end
    b_valid[DEPTH-1] = do_pop ? 1'b0 : valid_q[DEPTH-1];
    b_data[DEPTH-1]  = do_pop ? '0   : data_q[DEPTH-1];
    b_id[DEPTH-1]    = do_pop ? '0   : id_q[DEPTH-1];

    // Monotonic because the array is sorted and valid cells are contiguous.
    for (int i = 0; i < DEPTH; i++) begin
      ge[i] = !b_valid[i] || wins(push_data_i, b_data[i]);
    end

`ifdef PQ_EVICT_EN
    evict_ok = ge[DEPTH-1];
`else
    evict_ok = 1'b0;
`endif
    ins_en = push_i && (do_pop || !full_q || evict_ok);

    prev_ge = 1'b0;
    c_valid = 1'b0;
    c_data  = '0;
    c_id    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_en && ge[i] && !prev_ge) begin
        valid_d[i] = 1'b1;
        data_d[i]  = push_data_i;
        id_d[i]    = push_id_i;
      end else if (ins_en && ge[i]) begin
        valid_d[i] = c_valid;
        data_d[i]  = c_data;
        id_d[i]    = c_id;
      end else begin
        valid_d[i] = b_valid[i];
        data_d[i]  = b_data[i];
        id_d[i]    = b_id[i];
      end
      prev_ge = ge[i];
      c_valid = b_valid[i];
      c_data  = b_data[i];
      c_id    = b_id[i];
    end

    base_count = count_q - (do_pop ? CW'(1) : CW'(0));
    if (ins_en && (base_count != CW'(DEPTH))) begin
      count_d = base_count + CW'(1);
    end else begin
      count_d = base_count;
    end
    full_d      = (count_d == CW'(DEPTH));
    empty_d     = (count_d == CW'(0));
    overflow_d  = push_i && full_q && !pop_i;
    underflow_d = pop_i && empty_q;
  end

  // State registers with synchronous reset taking precedence over push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        id_q[i]    <= '0;
      end
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        data_q[i]  <= data_d[i];
        id_q[i]    <= id_d[i];
      end
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Invalid cells are always held at zero, so the head cell can drive the outputs directly.
  assign head_valid_o = valid_q[0];
  assign head_data_o  = data_q[0];
  assign head_id_o    = id_q[0];
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_param_array_pq.sv
// Table-driven bench for param_array_pq (DEPTH=4) plus a MAX_FIRST=1 hand-written sequence.
module tb_param_array_pq;

`ifdef PQ_EVICT_EN
  localparam bit EVICT = 1'b1;
`else
  localparam bit EVICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        a_rst, a_push, a_pop, b_rst, b_push, b_pop;
  logic [15:0] a_d, b_d, a_hd, b_hd;
  logic [2:0]  a_id, b_id, a_hid, b_hid, a_cnt, b_cnt;
  logic        a_hv, a_full, a_empty, a_ovf, a_unf;
  logic        b_hv, b_full, b_empty, b_ovf, b_unf;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  param_array_pq #(.DEPTH(4), .DATA_WIDTH(16), .MAX_FIRST(0)) u_min (
    .clk_i(clk), .rst_i(a_rst), .push_i(a_push), .push_data_i(a_d), .push_id_i(a_id),
    .pop_i(a_pop), .head_valid_o(a_hv), .head_data_o(a_hd), .head_id_o(a_hid),
    .count_o(a_cnt), .full_o(a_full), .empty_o(a_empty), .overflow_o(a_ovf),
    .underflow_o(a_unf));

  param_array_pq #(.DEPTH(4), .DATA_WIDTH(16), .MAX_FIRST(1)) u_max (
    .clk_i(clk), .rst_i(b_rst), .push_i(b_push), .push_data_i(b_d), .push_id_i(b_id),
    .pop_i(b_pop), .head_valid_o(b_hv), .head_data_o(b_hd), .head_id_o(b_hid),
    .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty), .overflow_o(b_ovf),
    .underflow_o(b_unf));

  typedef struct {
    logic        rst, push, pop;
    logic [15:0] d;
    logic [2:0]  id;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected word: {valid, data, id, count, full, empty, overflow, underflow}.
  function automatic vec_t r(input logic rst, push, pop, input int d, id,
                             input logic ev, input int ed, eid, ec, input logic eo, eu);
    vec_t v;
    v.rst = rst; v.push = push; v.pop = pop;
    v.d = 16'(d); v.id = 3'(id);
    v.exp = {ev, 16'(ed), 3'(eid), 3'(ec), (ec == 4), (ec == 0), eo, eu};
    return v;
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step_b(input logic rst, push, pop, input int d, id);
    @(negedge clk);
    b_rst = rst; b_push = push; b_pop = pop; b_d = 16'(d); b_id = 3'(id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_push = 1'b0; a_pop = 1'b0; a_d = 16'd0; a_id = 3'd0;
    b_rst = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_d = 16'd0; b_id = 3'd0;

    // Ordering: push 30,10,20 then drain; pop on empty.
    vecs.push_back(r(1,0,0, 0,0, 0, 0,0,0, 0,0));
    vecs.push_back(r(0,1,0,30,1, 1,30,1,1, 0,0));
    vecs.push_back(r(0,1,0,10,2, 1,10,2,2, 0,0));
    vecs.push_back(r(0,1,0,20,3, 1,10,2,3, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1,20,3,2, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1,30,1,1, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 0, 0,0,0, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 0, 0,0,0, 0,1));
    vecs.push_back(r(0,0,0, 0,0, 0, 0,0,0, 0,0));
    // Ties stay FIFO.
    vecs.push_back(r(0,1,0, 5,1, 1, 5,1,1, 0,0));
    vecs.push_back(r(0,1,0, 5,2, 1, 5,1,2, 0,0));
    vecs.push_back(r(0,1,0, 3,3, 1, 3,3,3, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, 5,1,2, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, 5,2,1, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 0, 0,0,0, 0,0));
    // Fill, then push 0 into a full queue.
    vecs.push_back(r(0,1,0, 1,1, 1, 1,1,1, 0,0));
    vecs.push_back(r(0,1,0, 2,2, 1, 1,1,2, 0,0));
    vecs.push_back(r(0,1,0, 3,3, 1, 1,1,3, 0,0));
    vecs.push_back(r(0,1,0, 4,4, 1, 1,1,4, 0,0));
    vecs.push_back(r(0,1,0, 0,5, 1, EVICT ? 0 : 1, EVICT ? 5 : 1, 4, 1,0));
    vecs.push_back(r(0,0,0, 0,0, 1, EVICT ? 0 : 1, EVICT ? 5 : 1, 4, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, EVICT ? 1 : 2, EVICT ? 1 : 2, 3, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, EVICT ? 2 : 3, EVICT ? 2 : 3, 2, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, EVICT ? 3 : 4, EVICT ? 3 : 4, 1, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 0, 0,0,0, 0,0));
    // Refill; equal key to tail is never evicted; push+pop on full.
    vecs.push_back(r(1,0,0, 0,0, 0, 0,0,0, 0,0));
    vecs.push_back(r(0,1,0, 1,1, 1, 1,1,1, 0,0));
    vecs.push_back(r(0,1,0, 2,2, 1, 1,1,2, 0,0));
    vecs.push_back(r(0,1,0, 3,3, 1, 1,1,3, 0,0));
    vecs.push_back(r(0,1,0, 4,4, 1, 1,1,4, 0,0));
    vecs.push_back(r(0,1,0, 4,7, 1, 1,1,4, 1,0));
    vecs.push_back(r(0,1,1, 2,6, 1, 2,2,4, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, 2,6,3, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, 3,3,2, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 1, 4,4,1, 0,0));
    vecs.push_back(r(0,0,1, 0,0, 0, 0,0,0, 0,0));
    // Push+pop on empty, then reset while pushing with count 3.
    vecs.push_back(r(0,1,1, 7,1, 1, 7,1,1, 0,1));
    vecs.push_back(r(0,1,0, 9,2, 1, 7,1,2, 0,0));
    vecs.push_back(r(0,1,0, 8,3, 1, 7,1,3, 0,0));
    vecs.push_back(r(1,1,0, 1,1, 0, 0,0,0, 0,0));
    vecs.push_back(r(0,0,0, 0,0, 0, 0,0,0, 0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      a_rst = vecs[i].rst; a_push = vecs[i].push; a_pop = vecs[i].pop;
      a_d = vecs[i].d; a_id = vecs[i].id;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i),
            {a_hv, a_hd, a_hid, a_cnt, a_full, a_empty, a_ovf, a_unf}, vecs[i].exp);
    end

    // Largest-first instance: push 3,9,5 then drain.
    step_b(1'b1, 1'b0, 1'b0, 0, 0);
    check("max_reset", {b_hv, b_hd, b_hid, b_cnt, b_full, b_empty, b_ovf, b_unf},
          {1'b0, 16'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    step_b(1'b0, 1'b1, 1'b0, 3, 1);
    step_b(1'b0, 1'b1, 1'b0, 9, 2);
    step_b(1'b0, 1'b1, 1'b0, 5, 3);
    check("max_head9", {b_hv, b_hd, b_hid, b_cnt, b_full, b_empty, b_ovf, b_unf},
          {1'b1, 16'd9, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    step_b(1'b0, 1'b0, 1'b1, 0, 0);
    check("max_pop5", {b_hv, b_hd, b_hid, b_cnt}, {1'b1, 16'd5, 3'd3, 3'd2});
    step_b(1'b0, 1'b0, 1'b1, 0, 0);
    check("max_pop3", {b_hv, b_hd, b_hid, b_cnt}, {1'b1, 16'd3, 3'd1, 3'd1});
    step_b(1'b0, 1'b0, 1'b1, 0, 0);
    check("max_empty", {b_hv, b_hd, b_hid, b_cnt, b_empty}, {1'b0, 16'd0, 3'd0, 3'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
